// File: rtl/uart_rx_core.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : uart_rx_core
// Description : UART receiver. Synchronises the asynchronous serial line,
//               detects the start-bit falling edge, re-checks the start bit
//               at mid-bit and then samples DATA_BITS data bits (LSB first)
//               and one stop bit at bit centre. Each good character is
//               delivered as a 1-cycle oRX_valid pulse; a low stop bit gives
//               a 1-cycle oFRAME_err pulse instead.
// Ports       : clk         - system clock
//               reset       - asynchronous, active-low reset
//               iRX         - serial line, idle high, asynchronous to clk
//               iRX_en      - receiver enable; low forces IDLE
//               oRX_data    - last good character, right-aligned, zero-filled
//               oRX_valid   - 1-cycle pulse when oRX_data is updated
//               oFRAME_err  - 1-cycle pulse when the stop bit is sampled low
//               oBUSY       - high whenever the receiver is not IDLE
//               oPARITY_err - (UART_RX_PARITY_EN only) 1-cycle pulse,
//                             coincident with oRX_valid/oFRAME_err, when the
//                             even-parity check fails
// Options     : define UART_RX_PARITY_EN to add an even-parity bit between
//               the data bits and the stop bit.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_core #(
    parameter int BAUD_MAX  = 10416,
    parameter int HALF_BIT  = BAUD_MAX / 2,
    parameter int DATA_BITS = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       iRX,
    input  logic       iRX_en,
    output logic [7:0] oRX_data,
    output logic       oRX_valid,
    output logic       oFRAME_err,
    output logic       oBUSY
`ifdef UART_RX_PARITY_EN
    ,
    output logic       oPARITY_err
`endif
);

    localparam logic [2:0]  c_st_idle   = 3'd0;
    localparam logic [2:0]  c_st_start  = 3'd1;
    localparam logic [2:0]  c_st_data   = 3'd2;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0]  c_st_parity = 3'd3;
`endif
    localparam logic [2:0]  c_st_stop   = 3'd4;

    localparam logic [13:0] c_baud_max  = 14'(BAUD_MAX);
    localparam logic [13:0] c_half_bit  = 14'(HALF_BIT);
    localparam logic [3:0]  c_last_idx  = 4'(DATA_BITS - 1);

    // Two-flop synchroniser plus one delay flop for falling-edge detection.
    logic                 r_sync1;
    logic                 r_rx_s;
    logic                 r_rx_d;
    logic                 w_fall;

    logic [2:0]           r_state;
    logic [13:0]          r_baud_cnt;
    logic [3:0]           r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic [7:0]           r_data;
    logic                 r_valid;
    logic                 r_ferr;
    logic                 w_cnt_last;
    logic [13:0]          w_cnt_next;
`ifdef UART_RX_PARITY_EN
    logic                 r_par_bad;
    logic                 r_perr;
`endif

    assign w_fall     = r_rx_d & ~r_rx_s;
    assign w_cnt_last = (r_baud_cnt == c_baud_max);
    assign w_cnt_next = w_cnt_last ? 14'd0 : r_baud_cnt + 14'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
            r_rx_d  <= 1'b1;
        end else begin
            r_sync1 <= iRX;
            r_rx_s  <= r_sync1;
            r_rx_d  <= r_rx_s;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= c_st_idle;
            r_baud_cnt <= 14'd0;
            r_bit_idx  <= 4'd0;
            r_shift    <= '0;
            r_data     <= 8'd0;
            r_valid    <= 1'b0;
            r_ferr     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bad  <= 1'b0;
            r_perr     <= 1'b0;
`endif
        end else begin
            // Result flags are single-cycle pulses.
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_perr  <= 1'b0;
`endif
            if (!iRX_en) begin
                // Disable discards any partial frame; oRX_data is kept.
                r_state    <= c_st_idle;
                r_baud_cnt <= 14'd0;
                r_bit_idx  <= 4'd0;
            end else begin
                case (r_state)
                    c_st_idle: begin
                        r_baud_cnt <= 14'd0;
                        if (w_fall) begin
                            r_state <= c_st_start;
                        end
                    end
                    c_st_start: begin
                        if (r_baud_cnt == c_half_bit) begin
                            // Still low at mid start bit: genuine start.
                            // Otherwise a glitch, return quietly.
                            r_state    <= r_rx_s ? c_st_idle : c_st_data;
                            r_baud_cnt <= 14'd0;
                            r_bit_idx  <= 4'd0;
                        end else begin
                            r_baud_cnt <= w_cnt_next;
                        end
                    end
                    c_st_data: begin
                        r_baud_cnt <= w_cnt_next;
                        if (w_cnt_last) begin
                            // LSB arrives first, so shift right from the top.
                            r_shift   <= {r_rx_s, r_shift[DATA_BITS-1:1]};
                            r_bit_idx <= r_bit_idx + 4'd1;
                            if (r_bit_idx == c_last_idx) begin
`ifdef UART_RX_PARITY_EN
                                r_state <= c_st_parity;
`else
                                r_state <= c_st_stop;
`endif
                            end
                        end
                    end
`ifdef UART_RX_PARITY_EN
                    c_st_parity: begin
                        r_baud_cnt <= w_cnt_next;
                        if (w_cnt_last) begin
                            // Even parity: data bits XOR parity bit must be 0.
                            r_par_bad <= (^r_shift) ^ r_rx_s;
                            r_state   <= c_st_stop;
                        end
                    end
`endif
                    c_st_stop: begin
                        r_baud_cnt <= w_cnt_next;
                        if (w_cnt_last) begin
                            // Leaving at mid stop bit lets the next start
                            // edge be caught during the remaining half bit.
                            r_state <= c_st_idle;
                            if (r_rx_s) begin
                                r_data  <= 8'(r_shift);
                                r_valid <= 1'b1;
                            end else begin
                                r_ferr  <= 1'b1;
                            end
`ifdef UART_RX_PARITY_EN
                            r_perr <= r_par_bad;
`endif
                        end
                    end
                    default: begin
                        r_state    <= c_st_idle;
                        r_baud_cnt <= 14'd0;
                    end
                endcase
            end
        end
    end

    assign oRX_data    = r_data;
    assign oRX_valid   = r_valid;
    assign oFRAME_err  = r_ferr;
    assign oBUSY       = (r_state != c_st_idle);
`ifdef UART_RX_PARITY_EN
    assign oPARITY_err = r_perr;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_core.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_uart_rx_core
// Description : Self-checking bench for uart_rx_core (BAUD_MAX=15,
//               HALF_BIT=7). Frames are driven bit by bit; each frame posts
//               its expected outcome (data or framing error, parity flag,
//               arrival cycle) to a scoreboard that a negedge monitor checks
//               against the DUT outputs every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_core;

    localparam int BAUD = 15;
    localparam int HALF = 7;
    localparam int NB   = 8;
    localparam int BITP = BAUD + 1;
`ifdef UART_RX_PARITY_EN
    localparam int PAR  = 1;
`else
    localparam int PAR  = 0;
`endif
    // sync(2) + edge(1) + half bit + data bits + (parity) + stop bit + output reg
    localparam int LAT  = 3 + HALF + NB * BITP + PAR * BITP + BITP + 1;

    logic       clk    = 1'b0;
    logic       reset  = 1'b0;
    logic       iRX    = 1'b1;
    logic       iRX_en = 1'b0;
    logic [7:0] oRX_data;
    logic       oRX_valid;
    logic       oFRAME_err;
    logic       oBUSY;
`ifdef UART_RX_PARITY_EN
    logic       oPARITY_err;
`endif

    uart_rx_core #(
        .BAUD_MAX  (BAUD),
        .HALF_BIT  (HALF),
        .DATA_BITS (NB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .iRX        (iRX),
        .iRX_en     (iRX_en),
        .oRX_data   (oRX_data),
        .oRX_valid  (oRX_valid),
        .oFRAME_err (oFRAME_err),
        .oBUSY      (oBUSY)
`ifdef UART_RX_PARITY_EN
        ,
        .oPARITY_err(oPARITY_err)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit         ferr;
        logic [7:0] data;
        int         when;
        bit         perr;
    } ev_t;

    ev_t        exp_q[$];
    ev_t        e_mon;
    logic [7:0] model_data     = 8'd0;
    int         n_valid        = 0;
    int         n_ferr         = 0;
    int         n_perr         = 0;
    int         last_valid_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: compares outputs against the scoreboard on every cycle.
    always @(negedge clk) begin
        if (reset) begin
            check("pulse_exclusive", {31'd0, oRX_valid & oFRAME_err}, 32'd0);
            if (oRX_valid || oFRAME_err) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", {30'd0, oRX_valid, oFRAME_err}, 32'd0);
                end else begin
                    e_mon = exp_q.pop_front();
                    check("pulse_kind_ferr", {31'd0, oFRAME_err}, {31'd0, e_mon.ferr});
                    check("pulse_time_window", {31'd0, (cyc >= e_mon.when - 1) && (cyc <= e_mon.when + 1)}, 32'd1);
`ifdef UART_RX_PARITY_EN
                    check("parity_flag", {31'd0, oPARITY_err}, {31'd0, e_mon.perr});
                    if (oPARITY_err) n_perr++;
`endif
                    if (!e_mon.ferr) begin
                        model_data     = e_mon.data;
                        n_valid++;
                        last_valid_cyc = cyc;
                    end else begin
                        n_ferr++;
                    end
                end
            end else begin
`ifdef UART_RX_PARITY_EN
                check("parity_idle_low", {31'd0, oPARITY_err}, 32'd0);
`endif
                if (exp_q.size() > 0 && cyc > exp_q[0].when + 1) begin
                    e_mon = exp_q.pop_front();
                    check("missed_pulse", {30'd0, oRX_valid, oFRAME_err}, e_mon.ferr ? 32'd1 : 32'd2);
                end
            end
            check("rx_data_hold", {24'd0, oRX_data}, {24'd0, model_data});
        end
    end

    task automatic drive_bit(input logic b);
        iRX = b;
        repeat (BITP) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        iRX = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par);
        ev_t e;
        e.ferr = ~stop;
        e.data = d;
        e.when = cyc + LAT;
        e.perr = (PAR != 0) && ((^d) ^ par);
        exp_q.push_back(e);
        drive_bit(1'b0);
        for (int i = 0; i < NB; i++) drive_bit(d[i]);
        if (PAR != 0) drive_bit(par);
        drive_bit(stop);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         t0;
        int         nv;
        logic [7:0] d;
        logic       st;
        logic       pb;

        // Reset state
        #2;
        check("rst_data",  {24'd0, oRX_data}, 32'd0);
        check("rst_valid", {31'd0, oRX_valid}, 32'd0);
        check("rst_ferr",  {31'd0, oFRAME_err}, 32'd0);
        check("rst_busy",  {31'd0, oBUSY}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        reset  = 1'b1;
        iRX_en = 1'b1;
        idle(20);

        // Single frame 0x55 with literal latency pin
        t0 = cyc;
        send_frame(8'h55, 1'b1, 1'b0);
        idle(4);
        check("single_data",    {24'd0, oRX_data}, 32'h55);
        check("single_nvalid",  n_valid, 32'd1);
        check("single_nferr",   n_ferr, 32'd0);
        check("single_latency", last_valid_cyc - t0, (PAR != 0) ? 32'd171 : 32'd155);
        check("single_busy",    {31'd0, oBUSY}, 32'd0);

        // Reset in the middle of 0xA5 (during bit 3)
        d = 8'hA5;
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(d[i]);
        iRX = d[3];
        repeat (8) @(posedge clk);
        #1;
        check("midrst_busy_before", {31'd0, oBUSY}, 32'd1);
        reset = 1'b0;
        model_data = 8'd0;
        exp_q.delete();
        #1;
        check("midrst_data",  {24'd0, oRX_data}, 32'd0);
        check("midrst_valid", {31'd0, oRX_valid}, 32'd0);
        check("midrst_ferr",  {31'd0, oFRAME_err}, 32'd0);
        check("midrst_busy",  {31'd0, oBUSY}, 32'd0);
        iRX = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        idle(10);
        send_frame(8'h3C, 1'b1, 1'b0);
        idle(4);
        check("after_rst_data",   {24'd0, oRX_data}, 32'h3C);
        check("after_rst_nvalid", n_valid, 32'd2);

        // Back-to-back frames, no idle gap
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        send_frame(8'h81, 1'b1, 1'b0);
        idle(4);
        check("b2b_nvalid", n_valid, 32'd5);
        check("b2b_data",   {24'd0, oRX_data}, 32'h81);

        // Glitch: 4 clk low then high
        iRX = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        iRX = 1'b1;
        check("glitch_busy_start", {31'd0, oBUSY}, 32'd1);
        repeat (10) @(posedge clk);
        #1;
        check("glitch_busy_end", {31'd0, oBUSY}, 32'd0);
        check("glitch_nvalid",   n_valid, 32'd5);
        idle(20);

        // Framing error, then line held low (break)
        send_frame(8'h12, 1'b0, 1'b0);
        iRX = 1'b0;
        repeat (48) @(posedge clk);
        #1;
        check("frame_nferr",  n_ferr, 32'd1);
        check("frame_nvalid", n_valid, 32'd5);
        check("frame_data",   {24'd0, oRX_data}, 32'h81);
        check("break_busy",   {31'd0, oBUSY}, 32'd0);
        idle(32);

        // Enable dropped during bit 5
        d = 8'h6B;
        drive_bit(1'b0);
        for (int i = 0; i < 5; i++) drive_bit(d[i]);
        iRX = d[5];
        repeat (8) @(posedge clk);
        #1;
        iRX_en = 1'b0;
        @(posedge clk);
        #1;
        check("en_drop_busy", {31'd0, oBUSY}, 32'd0);
        repeat (7) @(posedge clk);
        #1;
        for (int i = 6; i < NB; i++) drive_bit(d[i]);
        if (PAR != 0) drive_bit(1'b0);
        drive_bit(1'b1);
        idle(20);
        iRX_en = 1'b1;
        idle(10);
        check("en_drop_nvalid", n_valid, 32'd5);
        check("en_drop_data",   {24'd0, oRX_data}, 32'h81);

`ifdef UART_RX_PARITY_EN
        // 0x07 has odd weight: parity bit 0 is an error, 1 is good
        send_frame(8'h07, 1'b1, 1'b0);
        send_frame(8'h07, 1'b1, 1'b1);
        idle(4);
        check("parity_nperr",  n_perr, 32'd1);
        check("parity_nvalid", n_valid, 32'd7);
`endif

        // Randomized frames
        nv = 0;
        for (int k = 0; k < 24; k++) begin
            d  = 8'($urandom);
            st = ($urandom_range(0, 5) != 0);
            pb = 1'($urandom_range(0, 1));
            send_frame(d, st, pb);
            if (st) idle($urandom_range(0, 20));
            else    idle(BITP + $urandom_range(0, 20));
        end
        idle(40);
        check("queue_drained", exp_q.size(), 32'd0);
        check("final_busy",    {31'd0, oBUSY}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
- UART receiver; the receive-side counterpart of the TX baud generator/serializer path.
- Samples an asynchronous serial line and frames 8N1 characters: start bit, DATA_BITS data bits LSB first, one stop bit.
- Uses the same BAUD_MAX bit-period convention as TX: counter runs 0..BAUD_MAX, so one bit is BAUD_MAX+1 clk cycles.
- Delivers each received byte as a 1-cycle valid pulse to the RX FIFO / register interface.

Parameters:
- BAUD_MAX, 10416: last count value of the bit-period counter; bit period = BAUD_MAX+1 clk cycles; legal range 3..16383 (14-bit counter).
- HALF_BIT, BAUD_MAX/2: count at which the start bit is re-checked (mid-bit alignment).
- DATA_BITS, 8: data bits per frame; legal range 5..8.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- iRX  input  1  serial line, idle high; asynchronous to clk.
- iRX_en  input  1  receiver enable; low forces IDLE.
- oRX_data  output  8  last good character; unused upper bits are 0 when DATA_BITS<8.
- oRX_valid  output  1  1-cycle pulse when oRX_data is updated.
- oFRAME_err  output  1  1-cycle pulse when the stop bit is sampled low.
- oBUSY  output  1  high in any state other than IDLE.

Behaviour:
- Reset (reset=0, async): state=IDLE, counters=0, shift register=0, synchronizer flops=1. Outputs: oRX_data=0, oRX_valid=0, oFRAME_err=0, oBUSY=0.
- Input sync: iRX passes through 2 flops to give rx_s. A 3rd flop gives rx_d for edge detection. Edge detect = rx_d & ~rx_s.
- Bit counter, 14-bit (BAUD_CNT): cleared on every state entry. Increments each clk while not IDLE. Wraps BAUD_MAX->0.
- Bit index, 4-bit (BIT_IDX): counts data bits received.
- IDLE -> START: iRX_en=1 and a falling edge detected.
- START:
  - At BAUD_CNT==HALF_BIT, rx_s=0 -> DATA; BAUD_CNT and BIT_IDX cleared.
  - At BAUD_CNT==HALF_BIT, rx_s=1 -> false start, back to IDLE. No outputs.
- DATA:
  - At BAUD_CNT==BAUD_MAX, rx_s is shifted in at the MSB of the shift register (right shift, LSB first), and BIT_IDX increments.
  - On the DATA_BITS-th sample -> STOP.
  - Samples land at bit centre ±1 clk.
- STOP, at BAUD_CNT==BAUD_MAX:
  - rx_s=1: on the next clk edge, oRX_data is loaded with the shift register (right-aligned), oRX_valid=1 for exactly 1 cycle.
  - rx_s=0: oFRAME_err=1 for 1 cycle; oRX_data holds its old value; oRX_valid stays 0.
  - In both cases -> IDLE. Detection of the next start edge is allowed in the remaining half stop bit, so back-to-back frames are supported.
- Framing error with line held low (break): IDLE needs a new falling edge, so no spurious frames while the line stays low.
- iRX_en=0 in any state: next cycle state=IDLE, counters cleared, partial frame discarded, no pulses. oRX_data holds.
- Latency: from the start-bit falling edge at iRX to oRX_valid = 2 (sync) + 1 (edge) + HALF_BIT + DATA_BITS*(BAUD_MAX+1) + (BAUD_MAX+1) + 1 clk, ±1.
- oRX_valid and oFRAME_err are never high in the same cycle.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined:
  - Adds state PARITY between DATA and STOP, sampled at BAUD_CNT==BAUD_MAX.
  - Even parity: XOR of the data bits and the parity bit must be 0.
  - Adds port oPARITY_err (output, 1 bit, reset 0). It pulses 1 cycle together with oRX_valid/oFRAME_err timing when the check fails.
  - The byte is still delivered with oRX_valid; the flag qualifies it.
- Not defined: no PARITY state, no oPARITY_err port, pure 8N1.

Test Plan (BAUD_MAX=15, HALF_BIT=7):
- Reset mid-frame: send 0xA5, assert reset=0 at bit 3 -> all outputs 0 immediately. After release, a fresh 0x3C is received correctly.
- Single frame: drive 0x55 8N1 at 16 clk/bit -> one oRX_valid pulse, oRX_data=0x55, oFRAME_err=0, oBUSY low after the stop sample.
- Back-to-back: 0x00, 0xFF, 0x81 with no idle gap -> three valid pulses in order with matching data.
- Glitch: iRX low for 4 clk then high -> START aborts at count 7, no pulses, oBUSY returns 0.
- Framing: 0x12 with the stop bit driven 0 -> oFRAME_err 1-cycle pulse, no oRX_valid, oRX_data unchanged. The line held low afterwards produces no further pulses.
- Enable/parity: drop iRX_en in bit 5 -> no output, IDLE next cycle. With UART_RX_PARITY_EN, 0x07 with parity bit 0 -> oRX_valid plus oPARITY_err pulse; with parity bit 1 -> oPARITY_err=0.
